// File: rtl/rotate_pkg.sv
// Shared types for the ImageSpin rotation engine: rotation modes, FSM states
// and the frame side length derived from the frame buffer address width.
package rotate_pkg;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rot_state_t;

    // A square frame splits the address evenly into row and column halves.
    function automatic int side_len(input int addr_width);
        return 1 << (addr_width / 2);
    endfunction

endpackage : rotate_pkg

// File: rtl/rotate_addr_map.sv
// Combinational source-coordinate to destination-address map for the four
// supported rotations; N-1-v is taken as ~v so no adders are needed.
module rotate_addr_map
    import rotate_pkg::*;
#(
    parameter int COORD_W = 8
) (
    input  rot_mode_t            mode,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    output logic [2*COORD_W-1:0] addr
);

    always_comb begin
        addr = {y, x};
        case (mode)
            ROT_0:   addr = {y, x};
            ROT_90:  addr = {x, ~y};
            ROT_180: addr = {~y, ~x};
            ROT_270: addr = {~x, y};
            default: addr = {y, x};
        endcase
    end

endmodule : rotate_addr_map

// File: rtl/rotate_engine.sv
// Streams a square frame out of the source buffer one pixel per cycle and
// writes each pixel one cycle later to its rotated destination address.
module rotate_engine
    import rotate_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic                  src_en,
    output logic                  src_wr,
    input  logic [DATA_WIDTH-1:0] src_rd_data,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  dst_en,
    output logic                  dst_wr,
    output logic [DATA_WIDTH-1:0] dst_wr_data
);

    localparam int COORD_W = ADDR_WIDTH / 2;
    localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(side_len(ADDR_WIDTH) - 1);

    rot_state_t         state_q, state_d;
    rot_mode_t          mode_q, mode_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               wr_valid_q, wr_valid_d;
    logic [COORD_W-1:0] wr_x_q, wr_x_d;
    logic [COORD_W-1:0] wr_y_q, wr_y_d;
    logic [ADDR_WIDTH-1:0] mapped_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= ROT_0;
            x_q        <= '0;
            y_q        <= '0;
            wr_valid_q <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            y_q        <= y_d;
            wr_valid_q <= wr_valid_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
        end
    end

    // The write stage captures the coordinates of whatever was read this
    // cycle, so it is valid exactly in the cycle after each RUN cycle.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        x_d        = x_q;
        y_d        = y_q;
        wr_valid_d = 1'b0;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = rot_mode_t'(mode);
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_valid_d = 1'b1;
                wr_x_d     = x_q;
                wr_y_d     = y_q;
                x_d        = x_q + 1'b1;
                if (x_q == COORD_MAX) begin
                    y_d = y_q + 1'b1;
                    if (y_q == COORD_MAX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    rotate_addr_map #(
        .COORD_W (COORD_W)
    ) u_addr_map (
        .mode (mode_q),
        .x    (wr_x_q),
        .y    (wr_y_q),
        .addr (mapped_addr)
    );

    // Outputs decode straight from state so the async reset clears them at once.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        src_en      = (state_q == ST_RUN);
        src_wr      = 1'b0;
        src_addr    = src_en ? {y_q, x_q} : '0;
        dst_en      = wr_valid_q;
        dst_wr      = wr_valid_q;
        dst_addr    = wr_valid_q ? mapped_addr : '0;
        dst_wr_data = src_rd_data;
    end

endmodule : rotate_engine

// File: tb/tb_rotate_engine.sv
// Self-checking bench for rotate_engine on a 4x4 frame with behavioural
// source/destination buffers and a coordinate-level rotation model.
module tb_rotate_engine;

    localparam int DW = 24;
    localparam int AW = 4;
    localparam int N  = 4;
    localparam int NPIX = N * N;
    localparam int FRAME_CYCLES = NPIX + 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic [AW-1:0] src_addr;
    logic          src_en;
    logic          src_wr;
    logic [DW-1:0] src_rd_data;
    logic [AW-1:0] dst_addr;
    logic          dst_en;
    logic          dst_wr;
    logic [DW-1:0] dst_wr_data;

    logic [DW-1:0] src_mem [NPIX];
    logic [DW-1:0] dst_mem [NPIX];

    int check_count = 0;
    int pass_count  = 0;

    rotate_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .busy        (busy),
        .done        (done),
        .src_addr    (src_addr),
        .src_en      (src_en),
        .src_wr      (src_wr),
        .src_rd_data (src_rd_data),
        .dst_addr    (dst_addr),
        .dst_en      (dst_en),
        .dst_wr      (dst_wr),
        .dst_wr_data (dst_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source frame buffer: registered read, data one cycle after enable.
    always @(posedge clk) begin
        if (src_en && !src_wr) src_rd_data <= src_mem[src_addr];
    end

    // Destination index of source pixel (x, y) after rotating the image.
    function automatic int rotated_index(input int m, input int x, input int y);
        case (m)
            0:       return y * N + x;
            1:       return x * N + (N - 1 - y);
            2:       return (N - 1 - y) * N + (N - 1 - x);
            default: return (N - 1 - x) * N + y;
        endcase
    endfunction

    task automatic preload(input bit random_data);
        for (int i = 0; i < NPIX; i++)
            src_mem[i] = random_data ? DW'($urandom) : DW'(i);
    endtask

    // Runs one frame from an IDLE negedge, checking the cycle-by-cycle
    // handshake and then the whole destination against the model.
    task automatic run_frame(input logic [1:0] m, input bit hold, input string tag);
        int writes;
        logic exp_busy, exp_done, exp_src_en, exp_dst_en;
        logic [DW-1:0] exp_mem [NPIX];
        writes = 0;
        for (int i = 0; i < NPIX; i++) dst_mem[i] = 'x;
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        for (int c = 1; c <= FRAME_CYCLES + 1; c++) begin
            @(negedge clk);
            exp_busy   = (c <= FRAME_CYCLES);
            exp_done   = (c == FRAME_CYCLES);
            exp_src_en = (c <= NPIX);
            exp_dst_en = (c >= 2 && c <= NPIX + 1);
            check_count++;
            if (busy !== exp_busy)
                $display("[TB] FAIL %s busy cycle %0d: got %b want %b", tag, c, busy, exp_busy);
            else pass_count++;
            check_count++;
            if (done !== exp_done)
                $display("[TB] FAIL %s done cycle %0d: got %b want %b", tag, c, done, exp_done);
            else pass_count++;
            check_count++;
            if (src_en !== exp_src_en || src_wr !== 1'b0)
                $display("[TB] FAIL %s src_en/wr cycle %0d: got %b/%b want %b/0", tag, c, src_en, src_wr, exp_src_en);
            else pass_count++;
            check_count++;
            if (dst_en !== exp_dst_en || dst_wr !== exp_dst_en)
                $display("[TB] FAIL %s dst_en/wr cycle %0d: got %b/%b want %b", tag, c, dst_en, dst_wr, exp_dst_en);
            else pass_count++;
            if (exp_src_en) begin
                check_count++;
                if (src_addr !== AW'(c - 1))
                    $display("[TB] FAIL %s src_addr cycle %0d: got %0d want %0d", tag, c, src_addr, c - 1);
                else pass_count++;
            end
            if (dst_en === 1'b1 && dst_wr === 1'b1) begin
                writes++;
                dst_mem[dst_addr] = dst_wr_data;
            end
            if (hold && c < FRAME_CYCLES) begin
                start = 1'b1;
                mode  = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check_count++;
        if (writes != NPIX)
            $display("[TB] FAIL %s write strobes: got %0d want %0d", tag, writes, NPIX);
        else pass_count++;
        for (int a = 0; a < NPIX; a++)
            exp_mem[rotated_index(int'(m), a % N, a / N)] = src_mem[a];
        for (int i = 0; i < NPIX; i++) begin
            check_count++;
            if (dst_mem[i] !== exp_mem[i])
                $display("[TB] FAIL %s dst[%0d]: got %h want %h", tag, i, dst_mem[i], exp_mem[i]);
            else pass_count++;
        end
    endtask

    task automatic spot_check(input int idx, input logic [DW-1:0] want, input string tag);
        check_count++;
        if (dst_mem[idx] !== want)
            $display("[TB] FAIL %s dst[%0d]: got %0d want %0d", tag, idx, dst_mem[idx], want);
        else pass_count++;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check_count++;
        if ({busy, done, src_en, src_wr, dst_en, dst_wr} !== 6'b0 || src_addr !== '0 || dst_addr !== '0)
            $display("[TB] FAIL reset_outputs: got ctl=%b src_addr=%0d dst_addr=%0d want all zero",
                     {busy, done, src_en, src_wr, dst_en, dst_wr}, src_addr, dst_addr);
        else pass_count++;
        rst = 1'b0;
        @(negedge clk);
        check_count++;
        if (busy !== 1'b0)
            $display("[TB] FAIL idle_after_reset busy: got %b want 0", busy);
        else pass_count++;
    endtask

    task automatic test_modes_address_data();
        preload(1'b0);
        run_frame(2'd0, 1'b0, "mode0");
        run_frame(2'd1, 1'b0, "mode1");
        spot_check(7, 24'd1, "mode1");
        spot_check(2, 24'd4, "mode1");
        spot_check(3, 24'd0, "mode1");
        spot_check(12, 24'd15, "mode1");
        run_frame(2'd2, 1'b0, "mode2");
        spot_check(15, 24'd0, "mode2");
        spot_check(0, 24'd15, "mode2");
        spot_check(10, 24'd5, "mode2");
        run_frame(2'd3, 1'b0, "mode3");
        spot_check(8, 24'd1, "mode3");
        spot_check(12, 24'd0, "mode3");
        spot_check(3, 24'd15, "mode3");
    endtask

    task automatic test_start_held();
        preload(1'b1);
        run_frame(2'd1, 1'b1, "held_start_m1");
        run_frame(2'd2, 1'b1, "held_start_m2");
    endtask

    task automatic test_reset_mid_frame();
        int done_seen;
        preload(1'b0);
        start = 1'b1;
        mode  = 2'd2;
        @(posedge clk);
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_count++;
        if ({busy, done, src_en, src_wr, dst_en, dst_wr} !== 6'b0 || src_addr !== '0 || dst_addr !== '0)
            $display("[TB] FAIL midframe_reset_outputs: got ctl=%b src_addr=%0d dst_addr=%0d want all zero",
                     {busy, done, src_en, src_wr, dst_en, dst_wr}, src_addr, dst_addr);
        else pass_count++;
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check_count++;
        if (done_seen != 0)
            $display("[TB] FAIL midframe_reset_quiet: got %0d active cycles want 0", done_seen);
        else pass_count++;
        run_frame(2'd1, 1'b0, "after_reset_m1");
    endtask

    task automatic test_back_to_back();
        preload(1'b1);
        run_frame(2'd3, 1'b0, "b2b_first");
        run_frame(2'd0, 1'b0, "b2b_second");
    endtask

    task automatic test_random_frames();
        logic [1:0] m;
        for (int f = 0; f < 4; f++) begin
            preload(1'b1);
            m = 2'($urandom);
            run_frame(m, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_modes_address_data();
        test_start_held();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule : tb_rotate_engine
